// File: rtl/ram_req_ctrl.sv
// Generic circular FIFO that also exposes every slot and its occupancy so callers can snoop contents.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: the caller must not push when full; push and pop in the same cycle are both honoured.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic [DEPTH-1:0][W-1:0]    ent_dat,
    output logic [DEPTH-1:0]           ent_vld
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign head_dat = mem[rd_ptr];
    assign ent_dat  = mem;

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [AW-1:0] off;
        ent_vld = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, off} < cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop && !empty})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// RAM front end: buffered writes, pipelined reads with buffer-hazard stall, and whole-RAM zero fill.
// Latency: write reaches the RAM the cycle after accept; read data is qualified two edges after accept.
// Backpressure: wr_ready drops when the buffer is full or busy; rd_ready drops on a buffered-address hit or busy.
module ram_req_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_d_out
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wr_ent_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    localparam int ENT_W = $bits(wr_ent_t);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                           state;
    state_t                           state_nxt;
    logic [ADDR_W-1:0]                clr_cnt;
    logic                             wr_push;
    logic                             wr_pop;
    logic                             rd_acc;
    logic                             rd_pend;
    logic                             addr_hit;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [CNT_W-1:0]                 fifo_cnt;
    logic [ENT_W-1:0]                 head_raw;
    wr_ent_t                          head;
    wr_ent_t                          push_ent;
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] ent_dat;
    logic [FIFO_DEPTH-1:0]            ent_vld;

    assign push_ent = '{addr: wr_addr_in, dat: wr_data_in};
    assign head     = wr_ent_t'(head_raw);

    fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (wr_push),
        .push_dat (push_ent),
        .pop      (wr_pop),
        .head_dat (head_raw),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt),
        .ent_dat  (ent_dat),
        .ent_vld  (ent_vld)
    );

    // The head being popped this cycle still counts as a hit: its write lands on this edge.
    always_comb begin
        wr_ent_t e;
        addr_hit = 1'b0;
        e        = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            e = wr_ent_t'(ent_dat[i]);
            if (ent_vld[i] && (e.addr == rd_addr_in)) begin
                addr_hit = 1'b1;
            end
        end
    end

    assign wr_ready = (state == NORMAL) && !fifo_full;
    assign rd_ready = (state == NORMAL) && !addr_hit;
    assign wr_push  = wr_valid && wr_ready;
    assign rd_acc   = rd_valid && rd_ready;

    always_comb begin
        state_nxt   = state;
        wr_pop      = 1'b0;
        ram_wr      = 1'b0;
        ram_wr_addr = '0;
        ram_d_in    = '0;
        case (state)
            NORMAL: begin
                if (!fifo_empty) begin
                    wr_pop      = 1'b1;
                    ram_wr      = 1'b1;
                    ram_wr_addr = head.addr;
                    ram_d_in    = head.dat;
                end
                // A write accepted alongside clear_start must land before the fill starts.
                if (clear_start) begin
                    state_nxt = (!fifo_empty || wr_push) ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    wr_pop      = 1'b1;
                    ram_wr      = 1'b1;
                    ram_wr_addr = head.addr;
                    ram_d_in    = head.dat;
                end
                if (fifo_cnt <= CNT_W'(1)) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                ram_wr      = 1'b1;
                ram_wr_addr = clr_cnt;
                if (&clr_cnt) begin
                    state_nxt = NORMAL;
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            clear_busy <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            clear_busy <= (state_nxt != NORMAL);
            clr_cnt    <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rd_addr   <= '0;
            rd_pend       <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            if (rd_acc) begin
                ram_rd_addr <= rd_addr_in;
            end
            rd_pend       <= rd_acc;
            rd_data_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= ram_d_out;
            end
        end
    end
endmodule
